// File: rtl/b_reg_pkg.sv
// Shared types and defaults for the context-switching register bank.
package b_reg_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StRestore
    } state_e;

endpackage

// File: rtl/b_reg_ctx_fsm.sv
// Save/restore sequencer: walks idx over the bank once per operation and
// generates Busy, Done and the write handshake.
module b_reg_ctx_fsm
    import b_reg_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              save,
    input  logic              restore,
    output state_e            state,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              done,
    output logic              wr_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Save has priority when both requests arrive together.
                if (save) begin
                    state_d = StSave;
                    idx_d   = '0;
                end else if (restore) begin
                    state_d = StRestore;
                    idx_d   = '0;
                end
            end
            StSave, StRestore: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    assign state    = state_q;
    assign idx      = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_ready = !busy_q;

endmodule

// File: rtl/b_reg_ctx.sv
// Parametrised register bank with two combinational read ports, one write port
// and a shadow bank for interrupt context save/restore.
module b_reg_ctx
    import b_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Wr_en,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [WIDTH-1:0]  Wr_data,
    output logic              Wr_ready,
    input  logic [ADDR_W-1:0] Rd_addr_x,
    input  logic [ADDR_W-1:0] Rd_addr_y,
    output logic [WIDTH-1:0]  Rx,
    output logic [WIDTH-1:0]  Ry,
    input  logic              Save,
    input  logic              Restore,
    output logic              Busy,
    output logic              Done
);

    logic [WIDTH-1:0]  main_q   [DEPTH];
    logic [WIDTH-1:0]  shadow_q [DEPTH];
    state_e            state;
    logic [ADDR_W-1:0] idx;
    logic              wr_fire;
    logic              wr_commit;
    logic              rst_commit;
    logic              save_commit;

    b_reg_ctx_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .clk      (Clk),
        .rst_n    (Rst),
        .save     (Save),
        .restore  (Restore),
        .state    (state),
        .idx      (idx),
        .busy     (Busy),
        .done     (Done),
        .wr_ready (Wr_ready)
    );

    assign wr_fire     = Wr_en && Wr_ready;
    // A hard-zero register 0 never takes a write or a restored value.
    assign wr_commit   = wr_fire && !(ZERO_REG && (Wr_addr == '0));
    assign rst_commit  = (state == StRestore) && !(ZERO_REG && (idx == '0));
    assign save_commit = (state == StSave);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                main_q[i] <= '0;
            end
        end else begin
            if (wr_commit) begin
                main_q[Wr_addr] <= Wr_data;
            end
            if (rst_commit) begin
                main_q[idx] <= shadow_q[idx];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (save_commit) begin
            shadow_q[idx] <= main_q[idx];
        end
    end

    always_comb begin
        Rx = main_q[Rd_addr_x];
        Ry = main_q[Rd_addr_y];
        if (BYPASS && wr_fire && (Rd_addr_x == Wr_addr)) begin
            Rx = Wr_data;
        end
        if (BYPASS && wr_fire && (Rd_addr_y == Wr_addr)) begin
            Ry = Wr_data;
        end
        if (ZERO_REG && (Rd_addr_x == '0)) begin
            Rx = '0;
        end
        if (ZERO_REG && (Rd_addr_y == '0)) begin
            Ry = '0;
        end
    end

endmodule

// File: tb/tb_b_reg_ctx.sv
// Scoreboard bench: two bank variants (plain+bypass, zero-reg without bypass)
// driven in lockstep and checked against a behavioural model.
module tb_b_reg_ctx;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          Clk = 1'b1;
    logic          Rst = 1'b0;
    logic          Wr_en = 1'b0;
    logic [AW-1:0] Wr_addr = '0;
    logic [W-1:0]  Wr_data = '0;
    logic [AW-1:0] Rd_addr_x = '0;
    logic [AW-1:0] Rd_addr_y = '0;
    logic          Save = 1'b0;
    logic          Restore = 1'b0;

    logic [W-1:0]  rx_a, ry_a, rx_b, ry_b;
    logic          wr_ready_a, busy_a, done_a;
    logic          wr_ready_b, busy_b, done_b;

    always #5 Clk = ~Clk;

    b_reg_ctx #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ZERO_REG (1'b0),
        .BYPASS   (1'b1)
    ) dut_a (
        .Clk       (Clk),
        .Rst       (Rst),
        .Wr_en     (Wr_en),
        .Wr_addr   (Wr_addr),
        .Wr_data   (Wr_data),
        .Wr_ready  (wr_ready_a),
        .Rd_addr_x (Rd_addr_x),
        .Rd_addr_y (Rd_addr_y),
        .Rx        (rx_a),
        .Ry        (ry_a),
        .Save      (Save),
        .Restore   (Restore),
        .Busy      (busy_a),
        .Done      (done_a)
    );

    b_reg_ctx #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ZERO_REG (1'b1),
        .BYPASS   (1'b0)
    ) dut_b (
        .Clk       (Clk),
        .Rst       (Rst),
        .Wr_en     (Wr_en),
        .Wr_addr   (Wr_addr),
        .Wr_data   (Wr_data),
        .Wr_ready  (wr_ready_b),
        .Rd_addr_x (Rd_addr_x),
        .Rd_addr_y (Rd_addr_y),
        .Rx        (rx_b),
        .Ry        (ry_b),
        .Save      (Save),
        .Restore   (Restore),
        .Busy      (busy_b),
        .Done      (done_b)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] rx_a, ry_a, rx_b, ry_b;
        logic         busy, done, wr_ready;
        bit           chk_wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: bank contents, shadow, and the operation in flight
    // (op: 0 none, 1 save, 2 restore; rem: cycles of Busy still to run).
    logic [W-1:0] main_m   [D];
    logic [W-1:0] shadow_m [D];
    int           op     = 0;
    int           rem    = 0;
    bit           done_m = 1'b0;

    function automatic void model_clear();
        for (int i = 0; i < D; i++) begin
            main_m[i]   = '0;
            shadow_m[i] = '0;
        end
        op     = 0;
        rem    = 0;
        done_m = 1'b0;
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit zr, input bit byp);
        if (zr && a == 0) return '0;
        if (byp && Wr_en && op == 0 && a == Wr_addr) return Wr_data;
        return main_m[a];
    endfunction

    function automatic void model_edge();
        if (!Rst) begin
            model_clear();
        end else if (op != 0) begin
            if (op == 2) main_m[D - rem] = shadow_m[D - rem];
            rem    = rem - 1;
            done_m = (rem == 0);
            if (rem == 0) op = 0;
        end else begin
            done_m = 1'b0;
            if (Wr_en) main_m[Wr_addr] = Wr_data;
            if (Save) begin
                for (int i = 0; i < D; i++) shadow_m[i] = main_m[i];
                op  = 1;
                rem = D;
            end else if (Restore) begin
                op  = 2;
                rem = D;
            end
        end
    endfunction

    // One clock cycle: predict this cycle's outputs, then advance across the edge.
    task automatic step();
        exp_t e;
        if (!Rst) model_clear();
        e.cyc      = cyc;
        e.rx_a     = exp_rd(Rd_addr_x, 1'b0, 1'b1);
        e.ry_a     = exp_rd(Rd_addr_y, 1'b0, 1'b1);
        e.rx_b     = exp_rd(Rd_addr_x, 1'b1, 1'b0);
        e.ry_b     = exp_rd(Rd_addr_y, 1'b1, 1'b0);
        e.busy     = (op != 0);
        e.done     = done_m;
        e.wr_ready = (op == 0);
        e.chk_wr   = Rst;
        exp_q.push_back(e);
        @(posedge Clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int c, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rx_a", e.cyc, rx_a, e.rx_a);
            chk("ry_a", e.cyc, ry_a, e.ry_a);
            chk("rx_b", e.cyc, rx_b, e.rx_b);
            chk("ry_b", e.cyc, ry_b, e.ry_b);
            chk("busy_a", e.cyc, W'(busy_a), W'(e.busy));
            chk("busy_b", e.cyc, W'(busy_b), W'(e.busy));
            chk("done_a", e.cyc, W'(done_a), W'(e.done));
            chk("done_b", e.cyc, W'(done_b), W'(e.done));
            if (e.chk_wr) begin
                chk("wr_ready_a", e.cyc, W'(wr_ready_a), W'(e.wr_ready));
                chk("wr_ready_b", e.cyc, W'(wr_ready_b), W'(e.wr_ready));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        // Reset state.
        step();
        step();
        Rst = 1'b1;
        step();

        // Fill R0..R7 with 1..8, reading each address as it is written.
        for (int i = 0; i < D; i++) begin
            Wr_en = 1'b1; Wr_addr = AW'(i); Wr_data = W'(i + 1);
            Rd_addr_x = AW'(i); Rd_addr_y = AW'(D - 1 - i);
            step();
        end
        Wr_en = 1'b0;
        Rd_addr_x = 3; Rd_addr_y = 7; step();
        Rd_addr_x = 0; step();

        // Save, then bypass write, overwrite everything, restore.
        Save = 1'b1; step(); Save = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            Rd_addr_x = AW'(i); step();
        end
        Wr_en = 1'b1; Wr_addr = 5; Wr_data = 8'hA5; Rd_addr_x = 5; step();
        Wr_en = 1'b0; step();
        for (int i = 0; i < D; i++) begin
            Wr_en = 1'b1; Wr_addr = AW'(i); Wr_data = 8'hFF; Rd_addr_y = AW'(i); step();
        end
        Wr_en = 1'b0;
        Restore = 1'b1; step(); Restore = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            Rd_addr_x = AW'(i); Rd_addr_y = AW'(D - 1 - i); step();
        end
        for (int i = 0; i < D; i++) begin
            Rd_addr_x = AW'(i); Rd_addr_y = AW'(i); step();
        end

        // Write held across a save.
        Save = 1'b1; step(); Save = 1'b0;
        step(); step();
        Wr_en = 1'b1; Wr_addr = 2; Wr_data = 8'h55; Rd_addr_x = 2; Rd_addr_y = 2;
        repeat (D) step();
        Wr_en = 1'b0; step(); step();

        // Simultaneous requests, then a restore pulse during Busy.
        Save = 1'b1; Restore = 1'b1; step(); Save = 1'b0; Restore = 1'b0;
        step(); step();
        Restore = 1'b1; step(); Restore = 1'b0;
        repeat (D + 4) step();

        // Reset in the middle of a restore.
        Restore = 1'b1; step(); Restore = 1'b0;
        step(); step(); step();
        Rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            Rd_addr_x = AW'(i); Rd_addr_y = AW'(D - 1 - i); step();
        end
        Rst = 1'b1;
        Wr_en = 1'b1; Wr_addr = 4; Wr_data = 8'h3C; Rd_addr_x = 4; step();
        Wr_en = 1'b0; step();
        Restore = 1'b1; step(); Restore = 1'b0;
        for (int i = 0; i < D + 2; i++) begin
            Rd_addr_x = AW'(i); Rd_addr_y = 4; step();
        end

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            Rst       = ($urandom_range(0, 149) != 0);
            Wr_en     = Rst && ($urandom_range(0, 2) != 0);
            Wr_addr   = AW'($urandom);
            Wr_data   = W'($urandom);
            Rd_addr_x = ($urandom_range(0, 3) == 0) ? Wr_addr : AW'($urandom);
            Rd_addr_y = AW'($urandom);
            Save      = ($urandom_range(0, 15) == 0);
            Restore   = ($urandom_range(0, 15) == 0);
            step();
        end
        Rst = 1'b1; Wr_en = 1'b0; Save = 1'b0; Restore = 1'b0;
        repeat (D + 2) step();

        @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b_reg_ctx.md
Name: b_reg_ctx

Overview:
Parametrised successor to the 8x8 general-purpose register bank in the microprocessor datapath. Provides DEPTH registers of WIDTH bits, with two combinational read ports (Rx, Ry) and one write port. Adds an optional hard-zero register 0, optional write-to-read bypass, and a shadow bank with a multi-cycle save/restore engine for interrupt context switching. Sits between the control unit (addresses, enables) and the ALU operand inputs.

Parameters:
WIDTH, 8, data width of each register
DEPTH, 8, number of registers (power of two, >=2)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are discarded
BYPASS, 1, 1 = a read of the address being written this cycle returns Wr_data

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Wr_en  in  1  write request
Wr_addr  in  ADDR_W  write address
Wr_data  in  WIDTH  write data
Wr_ready  out  1  write accepted this cycle when high
Rd_addr_x  in  ADDR_W  read port X address
Rd_addr_y  in  ADDR_W  read port Y address
Rx  out  WIDTH  read port X data (combinational)
Ry  out  WIDTH  read port Y data (combinational)
Save  in  1  request: copy main bank to shadow bank
Restore  in  1  request: copy shadow bank to main bank
Busy  out  1  save/restore in progress
Done  out  1  one-cycle pulse when save/restore completes

Behaviour:
- Reset (Rst low, async): all main and shadow registers cleared to 0. FSM goes to IDLE, index counter to 0, Busy=0, Done=0. Wr_ready=1 once Rst deasserts. Reset mid-save or mid-restore aborts the operation and leaves no partial state.
- Wr_ready = !Busy (combinational). A write commits at the rising edge when Wr_en && Wr_ready. Wr_en while Busy is ignored; the producer must hold the request.
- Reads are combinational from the main bank. With BYPASS=1, Wr_en && Wr_ready && Rd_addr==Wr_addr makes Rx/Ry return Wr_data. With ZERO_REG=1, address 0 reads 0 regardless of bypass.
- FSM states: IDLE, SAVE, RESTORE. A registered index idx (ADDR_W bits) is used in SAVE and RESTORE.
- IDLE: if Save is sampled high -> SAVE, idx=0. Otherwise, if Restore is sampled high -> RESTORE, idx=0. Save wins when both are high. A write accepted on that same edge lands in the main bank before copying starts, so it is included in a save.
- SAVE: on each edge shadow[idx] <= main[idx] and idx++. After the edge that copies idx=DEPTH-1 -> IDLE, with Done=1 for the following cycle.
- RESTORE: on each edge main[idx] <= shadow[idx] and idx++. Termination is the same as SAVE. With ZERO_REG=1, register 0 stays 0.
- Busy is registered, equals (state!=IDLE), and is high for exactly DEPTH cycles per operation. Save/Restore pulses while Busy are ignored, not queued.
- Reads during RESTORE return partially restored contents. The consumer must stall on Busy.
- idx wraps naturally at DEPTH-1 -> 0. No other width growth occurs; all data paths are WIDTH bits with no truncation.

Decomposition:
- The shared package b_reg_pkg holds the FSM state enum (IDLE, SAVE, RESTORE) and default WIDTH/DEPTH constants.
- One natural sub-module, b_reg_ctx_fsm: FSM, idx counter, Busy/Done/Wr_ready generation. The storage arrays and read muxes stay in the top level.

Test Plan:
1. Reset, then write R0..R7 = 8'h01..8'h08 on consecutive cycles. Read Rx=R3, Ry=R7 -> 8'h04, 8'h08. With ZERO_REG=1, Rx=R0 -> 8'h00.
2. Bypass: write R5=8'hA5 and read Rd_addr_x=5 in the same cycle -> Rx=8'hA5 before the edge (BYPASS=1). With BYPASS=0 -> old value 8'h06.
3. Save after test 1, then overwrite all registers with 8'hFF, then Restore. Each operation gives Busy high for exactly 8 cycles and one Done pulse; afterwards R1..R7 read 8'h02..8'h08.
4. Assert Wr_en R2=8'h55 mid-save (cycle 3 of Busy) -> Wr_ready=0, R2 unchanged. Holding Wr_en commits it on the first cycle after Busy falls.
5. Save and Restore high together in IDLE -> SAVE is taken. Restore pulsed during Busy -> ignored, with no second operation afterwards.
6. Drop Rst low at cycle 4 of a restore -> all registers and shadow read 0 immediately; Busy=0, Done=0. After release, normal writes work.
